button_event_arbiter: RTL and testbench



---
 rtl/button_event_arbiter_if.sv | 23 ++
 rtl/button_event_arbiter.sv | 159 +++++++++++++++
 tb/tb_button_event_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/button_event_arbiter_if.sv
// Single-event channel between the button arbiter and its consumer.
// The arbiter drives valid/id and holds them until the consumer raises ready.
interface button_event_arbiter_if #(
  parameter int ID_W = 2
);

  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic            evt_ready;

  modport master (
    output evt_valid,
    output evt_id,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    output evt_ready
  );

endinterface

// File: rtl/button_event_arbiter.sv
// Button event arbiter: queues one pending press per button and hands the
// queued presses out one at a time, round-robin, on a valid/ready channel.
// After every accepted event the channel stays quiet for GAP_CYCLES clocks
// so the downstream UI FSM never sees events back to back.
module button_event_arbiter #(
  parameter int N_BTN      = 4,
  parameter int ID_W       = 2,
  parameter int GAP_CYCLES = 16,
  parameter int GAP_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_BTN-1:0]      btn_pulse,
  button_event_arbiter_if.master evt_if,
  output logic [N_BTN-1:0]      pending,
  output logic [N_BTN-1:0]      overrun,
  input  logic                  overrun_clr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;

  // Value loaded into the gap counter on a handshake; the counter then runs
  // down to zero, which gives exactly GAP_CYCLES cycles in the GAP state.
  localparam logic [GAP_W-1:0] GAP_LOAD =
    (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);
  localparam bit HAS_GAP = (GAP_CYCLES != 0);

  state_t           state_q,     state_d;
  logic             evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]  evt_id_q,    evt_id_d;
  logic [N_BTN-1:0] pending_q,   pending_d;
  logic [N_BTN-1:0] overrun_q,   overrun_d;
  logic [ID_W-1:0]  rr_ptr_q,    rr_ptr_d;
  logic [GAP_W-1:0] gap_cnt_q,   gap_cnt_d;

  logic             arb_found;
  logic [ID_W-1:0]  arb_idx;
  logic [N_BTN-1:0] arb_onehot;
  logic             grant;
  logic [N_BTN-1:0] grant_vec;
  logic [N_BTN-1:0] ovr_set;

  // Modular add on button indices, so non-power-of-two N_BTN wraps correctly.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int              off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_BTN) begin
      sum = sum - N_BTN;
    end
    return ID_W'(sum);
  endfunction

  // Round-robin search: first pending button at or after rr_ptr, wrapping.
  always_comb begin
    logic [ID_W-1:0] cand;
    arb_found  = 1'b0;
    arb_idx    = '0;
    arb_onehot = '0;
    cand       = '0;
    for (int k = 0; k < N_BTN; k++) begin
      cand = wrap_add(rr_ptr_q, k);
      if (!arb_found && pending_q[cand]) begin
        arb_found        = 1'b1;
        arb_idx          = cand;
        arb_onehot[cand] = 1'b1;
      end
    end
  end

  // Event channel FSM: grant from IDLE, hold in PRESENT, then enforce the gap.
  always_comb begin
    state_d     = state_q;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    rr_ptr_d    = rr_ptr_q;
    gap_cnt_d   = gap_cnt_q;
    grant       = 1'b0;

    case (state_q)
      IDLE: begin
        evt_valid_d = 1'b0;
        if (arb_found) begin
          grant       = 1'b1;
          evt_valid_d = 1'b1;
          evt_id_d    = arb_idx;
          rr_ptr_d    = wrap_add(arb_idx, 1);
          state_d     = PRESENT;
        end
      end

      PRESENT: begin
        if (evt_if.evt_ready) begin
          evt_valid_d = 1'b0;
          if (HAS_GAP) begin
            gap_cnt_d = GAP_LOAD;
            state_d   = GAP;
          end else begin
            state_d = IDLE;
          end
        end
      end

      GAP: begin
        evt_valid_d = 1'b0;
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      default: begin
        evt_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // Press capture: a press landing on a slot that is being granted re-queues
  // it; a press landing on a slot that stays pending is lost and flagged.
  always_comb begin
    grant_vec = grant ? arb_onehot : '0;
    ovr_set   = btn_pulse & pending_q & ~grant_vec;
    pending_d = (pending_q & ~grant_vec) | btn_pulse;
    overrun_d = (overrun_q & {N_BTN{~overrun_clr}}) | ovr_set;
  end

  // State register; reset discards any event in flight and all queued presses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      pending_q   <= '0;
      overrun_q   <= '0;
      rr_ptr_q    <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      rr_ptr_q    <= rr_ptr_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign evt_if.evt_valid = evt_valid_q;
  assign evt_if.evt_id    = evt_id_q;
  assign pending          = pending_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with the default 4-button,
// 16-cycle-gap configuration.
module tb_button_event_arbiter;

  localparam int N_BTN      = 4;
  localparam int ID_W       = 2;
  localparam int GAP_CYCLES = 16;
  localparam int GAP_W      = 8;
  localparam int PERIOD     = GAP_CYCLES + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_BTN-1:0] btn_pulse;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] overrun;
  logic             overrun_clr;

  int total = 0;
  int bad   = 0;
  int ev_id[$];
  int ev_tick[$];
  int stable;

  button_event_arbiter_if #(.ID_W(ID_W)) evt_if ();

  button_event_arbiter #(
    .N_BTN(N_BTN),
    .ID_W(ID_W),
    .GAP_CYCLES(GAP_CYCLES),
    .GAP_W(GAP_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_pulse(btn_pulse),
    .evt_if(evt_if),
    .pending(pending),
    .overrun(overrun),
    .overrun_clr(overrun_clr)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic r, input logic [N_BTN-1:0] b,
                                input logic rdy, input logic clr);
    rst              = r;
    btn_pulse        = b;
    evt_if.evt_ready = rdy;
    overrun_clr      = clr;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks, logging every cycle in which evt_valid is high.
  task automatic watch(input int n);
    ev_id.delete();
    ev_tick.delete();
    for (int i = 1; i <= n; i++) begin
      tick();
      if (evt_if.evt_valid === 1'b1) begin
        ev_id.push_back(int'(evt_if.evt_id));
        ev_tick.push_back(i);
      end
    end
  endtask

  function automatic int ev_id_at(input int k);
    return (k < ev_id.size()) ? ev_id[k] : -1;
  endfunction

  function automatic int ev_tick_at(input int k);
    return (k < ev_tick.size()) ? ev_tick[k] : -1;
  endfunction

  // Linear directed sequence; each block leaves the DUT idle for the next.
  initial begin
    // Reset holds everything at zero even with presses on every button.
    apply_stimulus(1'b1, 4'b1111, 1'b0, 1'b0);
    tick();
    tick();
    check_output("rst_valid",   evt_if.evt_valid, 1'b0);
    check_output("rst_id",      evt_if.evt_id,    2'd0);
    check_output("rst_pending", pending,          4'b0000);
    check_output("rst_overrun", overrun,          4'b0000);

    // Single press on button 2: pending next cycle, valid the cycle after.
    apply_stimulus(1'b0, 4'b0100, 1'b1, 1'b0);
    tick();
    check_output("t1_pending", pending,          4'b0100);
    check_output("t1_valid0",  evt_if.evt_valid, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    tick();
    check_output("t1_valid1",  evt_if.evt_valid, 1'b1);
    check_output("t1_id",      evt_if.evt_id,    2'd2);
    check_output("t1_pend_gr", pending,          4'b0000);
    tick();
    check_output("t1_valid_lo", evt_if.evt_valid, 1'b0);
    watch(20);
    check_output("t1_gap_quiet", ev_id.size(), 0);
    check_output("t1_pend_end",  pending,      4'b0000);
    check_output("t1_ovr_end",   overrun,      4'b0000);

    // All four buttons at once after a fresh reset: served 0,1,2,3.
    apply_stimulus(1'b1, 4'b0000, 1'b1, 1'b0);
    tick();
    apply_stimulus(1'b0, 4'b1111, 1'b1, 1'b0);
    tick();
    check_output("t2_pending", pending, 4'b1111);
    apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    watch(80);
    check_output("t2_count", ev_id.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check_output($sformatf("t2_id%0d", k),   ev_id_at(k),   k);
      check_output($sformatf("t2_tick%0d", k), ev_tick_at(k), 1 + PERIOD * k);
    end

    // Pointer wrapped back to 0: button 0 beats button 3.
    apply_stimulus(1'b0, 4'b1001, 1'b1, 1'b0);
    tick();
    apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    tick();
    check_output("t2_wrap_valid", evt_if.evt_valid, 1'b1);
    check_output("t2_wrap_id",    evt_if.evt_id,    2'd0);
    watch(45);
    check_output("t2_wrap_cnt", ev_id.size(), 1);
    check_output("t2_wrap_id3", ev_id_at(0),  3);

    // Consumer stalls 20 cycles: event held stable, then accepted.
    apply_stimulus(1'b0, 4'b0010, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    tick();
    check_output("t3_valid", evt_if.evt_valid, 1'b1);
    check_output("t3_id",    evt_if.evt_id,    2'd1);
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (evt_if.evt_valid === 1'b1 && evt_if.evt_id === 2'd1) begin
        stable++;
      end
    end
    check_output("t3_stable", stable, 20);
    apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    tick();
    check_output("t3_accept", evt_if.evt_valid, 1'b0);
    watch(20);
    check_output("t3_gap_quiet", ev_id.size(), 0);

    // Overrun on button 3 while its event waits behind a stalled button 2.
    apply_stimulus(1'b0, 4'b0100, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    tick();
    check_output("t4_id2", evt_if.evt_id, 2'd2);
    apply_stimulus(1'b0, 4'b1000, 1'b0, 1'b0);
    tick();
    check_output("t4_pend3",  pending, 4'b1000);
    check_output("t4_noovr",  overrun, 4'b0000);
    tick();
    check_output("t4_ovr",    overrun, 4'b1000);
    apply_stimulus(1'b0, 4'b1000, 1'b0, 1'b1);
    tick();
    check_output("t4_clr_vs_set", overrun, 4'b1000);
    apply_stimulus(1'b0, 4'b0000, 1'b0, 1'b1);
    tick();
    check_output("t4_clr",     overrun, 4'b0000);
    check_output("t4_pend_kept", pending, 4'b1000);
    check_output("t4_held",    evt_if.evt_valid, 1'b1);
    apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    tick();
    watch(40);
    check_output("t4_one_evt", ev_id.size(), 1);
    check_output("t4_evt_id3", ev_id_at(0),  3);

    // Press on button 0 in its own grant cycle re-queues it.
    apply_stimulus(1'b0, 4'b0001, 1'b1, 1'b0);
    tick();
    tick();
    check_output("t5_valid",   evt_if.evt_valid, 1'b1);
    check_output("t5_id",      evt_if.evt_id,    2'd0);
    check_output("t5_requeue", pending,          4'b0001);
    check_output("t5_noovr",   overrun,          4'b0000);
    apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    watch(45);
    check_output("t5_second_cnt", ev_id.size(), 1);
    check_output("t5_second_id",  ev_id_at(0),  0);
    check_output("t5_second_tk",  ev_tick_at(0), PERIOD);
    check_output("t5_ovr_end",    overrun,      4'b0000);

    // Reset while presenting with two more presses queued.
    apply_stimulus(1'b0, 4'b0001, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 4'b0110, 1'b0, 1'b0);
    tick();
    check_output("t6_valid", evt_if.evt_valid, 1'b1);
    check_output("t6_pend",  pending,          4'b0110);
    apply_stimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    tick();
    check_output("t6_rst_valid", evt_if.evt_valid, 1'b0);
    check_output("t6_rst_id",    evt_if.evt_id,    2'd0);
    check_output("t6_rst_pend",  pending,          4'b0000);
    check_output("t6_rst_ovr",   overrun,          4'b0000);
    apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    watch(40);
    check_output("t6_quiet", ev_id.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
